cuasi_alu_arbiter: RTL and testbench

Shares one 4-bit add/AND unit between two requesters. Each requester raises a request with two operands and an op select. The block arbitrates round-robin, latches the winner's operands, and sequences the operation through the unit. It then returns a registered result with a one-cycle done pulse to the winner. It sits between two client blocks and the shared unit (sel=0 add, sel=1 AND) and contains that unit internally.

---
 rtl/cuasi_alu_arbiter.sv | 139 +++++++++++++
 tb/tb_cuasi_alu_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cuasi_alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared WIDTH-bit add/AND unit.
// Each operation runs IDLE -> EXEC -> DONE, and a one-cycle done pulse goes back to the winner.
module cuasi_alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             op1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ptr;
  logic               r_win;
  logic               r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_done0;
  logic               r_done1;
  logic               r_busy;
  logic [CNT_W-1:0]   r_ops_cnt;

  logic               w_gnt_vld;
  logic               w_gnt_id;
  logic [WIDTH:0]     w_alu;

  // Shared unit: op=0 adds with carry-out in the MSB, op=1 is a bitwise AND with no carry.
  function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             op);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (op) begin
      alu_eval = {1'b0, a & b};
    end else begin
      alu_eval = sum;
    end
  endfunction

  // A lone requester always wins. When both request, the pointer breaks the tie.
  always_comb begin
    w_gnt_vld = req0 | req1;
    w_gnt_id  = 1'b0;
    if (req0 && req1) begin
      w_gnt_id = r_ptr;
    end else if (req1) begin
      w_gnt_id = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_alu = alu_eval(r_a, r_b, r_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_ptr     <= 1'b0;
      r_win     <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_ops_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (r_state == IDLE && w_gnt_vld) begin
        r_win <= w_gnt_id;
      end
      // The EXEC->DONE edge publishes the result, so the count and pointer move with done.
      if (r_state == EXEC) begin
        r_done0   <= ~r_win;
        r_done1   <= r_win;
        r_ops_cnt <= r_ops_cnt + CNT_W'(1);
        r_ptr     <= ~r_win;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_gnt_vld) begin
        r_a  <= w_gnt_id ? a1  : a0;
        r_b  <= w_gnt_id ? b1  : b0;
        r_op <= w_gnt_id ? op1 : op0;
      end
      if (r_state == EXEC) begin
        r_result <= w_alu[WIDTH-1:0];
        r_carry  <= w_alu[WIDTH];
      end
    end
  end

  assign done0   = r_done0;
  assign done1   = r_done1;
  assign result  = r_result;
  assign carry   = r_carry;
  assign busy    = r_busy;
  assign ops_cnt = r_ops_cnt;

endmodule

// File: tb/tb_cuasi_alu_arbiter.sv
// Directed bench for cuasi_alu_arbiter: a vector table of single-requester ops followed by
// hand-written contention, counter-wrap, drop-in-EXEC and reset-abort sequences.
module tb_cuasi_alu_arbiter;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic             done0, done1, carry, busy;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] ops_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cuasi_alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .done0(done0), .done1(done1), .result(result), .carry(carry),
    .busy(busy), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             r0;
    logic [WIDTH-1:0] va0;
    logic [WIDTH-1:0] vb0;
    logic             o0;
    logic             r1;
    logic [WIDTH-1:0] va1;
    logic [WIDTH-1:0] vb1;
    logic             o1;
    logic             e_d0;
    logic             e_d1;
    logic [WIDTH-1:0] e_res;
    logic             e_c;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Step clock edges until a done pulse shows up; cyc reports how many edges that took.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done0 || done1) return;
    end
    check("done_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int exp_cnt;

    vecs[0] = '{1'b1, 4'd8,  4'd6, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd14, 1'b0};
    vecs[1] = '{1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd8, 4'd6, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0};
    vecs[2] = '{1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 4'd2,  1'b1};
    vecs[3] = '{1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd10,4'd2, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0};
    vecs[4] = '{1'b1, 4'd15, 4'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1};
    vecs[5] = '{1'b1, 4'd15, 4'd9, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9,  1'b0};
    vecs[6] = '{1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd7, 4'd8, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0};

    // Reset then idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_outputs", {done0, done1, result, carry, busy, ops_cnt}, 0);
    end

    // Table of single-requester operations
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      req0 = vecs[i].r0; a0 = vecs[i].va0; b0 = vecs[i].vb0; op0 = vecs[i].o0;
      req1 = vecs[i].r1; a1 = vecs[i].va1; b1 = vecs[i].vb1; op1 = vecs[i].o1;
      wait_done(cyc);
      exp_cnt++;
      check($sformatf("v%0d_latency", i), cyc, 2);
      check($sformatf("v%0d_done0", i), done0, vecs[i].e_d0);
      check($sformatf("v%0d_done1", i), done1, vecs[i].e_d1);
      check($sformatf("v%0d_result", i), result, vecs[i].e_res);
      check($sformatf("v%0d_carry", i), carry, vecs[i].e_c);
      check($sformatf("v%0d_ops_cnt", i), ops_cnt, exp_cnt);
      check($sformatf("v%0d_busy", i), busy, 1);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_end", i), {done0, done1, busy}, 0);
      check($sformatf("v%0d_result_hold", i), {result, carry}, {vecs[i].e_res, vecs[i].e_c});
    end

    // Contention from reset: requester 0 first, then 1, then strict alternation
    do_reset();
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd2; op0 = 1'b0;
    req1 = 1'b1; a1 = 4'd1; b1 = 4'd5; op1 = 1'b0;
    wait_done(cyc);
    check("cont_first_done0", {done0, done1}, 2'b10);
    check("cont_first_result", result, 5);
    req0 = 1'b0;
    wait_done(cyc);
    check("cont_second_done1", {done0, done1}, 2'b01);
    check("cont_second_result", result, 6);
    req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_done(cyc);
      check($sformatf("rr%0d_grant", i), {done0, done1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_result", i), result, (i % 2 == 0) ? 5 : 6);
    end
    check("rr_ops_cnt", ops_cnt, 8);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Counter wrap with back-to-back service
    do_reset();
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd1; op0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wait_done(cyc);
      check($sformatf("wrap%0d_result", i), {done0, done1, result}, {2'b10, 4'd2});
      check($sformatf("wrap%0d_cnt", i), ops_cnt, (i + 1) % 256);
    end
    req0 = 1'b0;
    @(posedge clk); #1;

    // Request and operands dropped during EXEC do not cancel the operation
    do_reset();
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd4; op0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; a0 = 4'd0; b0 = 4'd0;
    wait_done(cyc);
    check("drop_done0", {done0, done1}, 2'b10);
    check("drop_result", result, 4);
    check("drop_latency", cyc, 1);

    // Reset mid-operation aborts and clears the pointer
    do_reset();
    req0 = 1'b1; a0 = 4'd8; b0 = 4'd6; op0 = 1'b0;
    wait_done(cyc);
    check("pre_abort_result", result, 14);
    req0 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {done0, done1, result, carry, busy, ops_cnt}, 0);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("abort_no_done", {done0, done1}, 0);
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd2;
    req1 = 1'b1; a1 = 4'd1; b1 = 4'd5; op1 = 1'b0;
    wait_done(cyc);
    check("post_abort_ptr", {done0, done1}, 2'b10);
    check("post_abort_cnt", ops_cnt, 1);
    req0 = 1'b0;
    wait_done(cyc);
    check("post_abort_req1", {done0, done1, result}, {2'b01, 4'd6});
    req1 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
